// File: rtl/seven_seg_pkg.sv
// Shared definitions for the multiplexed seven-segment driver.
//   GLYPH_HEX   : hex glyph table, index = nibble value, bits {g,f,e,d,c,b,a}
//   GLYPH_BLANK : glyph with every segment dark
//   seg_pol     : maps a "1 = lit" segment vector onto the pin polarity
//   dp_pol      : same mapping for the single decimal-point pin
package seven_seg_pkg;

  localparam logic [6:0] GLYPH_BLANK = 7'h00;

  // Entry 15 is leftmost, so GLYPH_HEX[v] yields the glyph for nibble v.
  localparam logic [15:0][6:0] GLYPH_HEX = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [6:0] seg_pol(input logic [6:0] lit, input logic act_lo);
    seg_pol = act_lo ? ~lit : lit;
  endfunction

  function automatic logic dp_pol(input logic lit, input logic act_lo);
    dp_pol = act_lo ? ~lit : lit;
  endfunction

endpackage

// File: rtl/seven_seg_scan_timer.sv
// Scan timing for the seven-segment multiplexer.
// A free-running DIV_BITS divider defines one scan slot; at the last cycle
// of each slot the digit index advances, wrapping DIGITS-1 -> 0.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   idx_o          digit currently being scanned
//   wrap_o         last cycle of the last slot of a frame
//   phase_o        top PWM_BITS of the divider (PWM phase within the slot)
//   slot_live_o    divider has passed the anti-ghost blanking window
module seven_seg_scan_timer
  import seven_seg_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int DIV_BITS  = 10,
  parameter int PWM_BITS  = 3,
  parameter int BLANK_CYC = 4,
  parameter int IDX_W     = 2
) (
  input  logic                clk,
  input  logic                rst,
  output logic [IDX_W-1:0]    idx_o,
  output logic                wrap_o,
  output logic [PWM_BITS-1:0] phase_o,
  output logic                slot_live_o
);

  localparam logic [DIV_BITS-1:0] DIV_MAX   = {DIV_BITS{1'b1}};
  localparam logic [DIV_BITS-1:0] BLANK_LIM = DIV_BITS'(BLANK_CYC);
  localparam logic [IDX_W-1:0]    IDX_LAST  = IDX_W'(DIGITS - 1);

  logic [DIV_BITS-1:0] div_q, div_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                tick_s;

  assign tick_s      = (div_q == DIV_MAX);
  assign wrap_o      = tick_s && (idx_q == IDX_LAST);
  assign idx_o       = idx_q;
  assign phase_o     = div_q[DIV_BITS-1 -: PWM_BITS];
  assign slot_live_o = (div_q >= BLANK_LIM);

  // Next-state for divider and digit index; explicit compare keeps
  // non-power-of-two digit counts wrapping correctly.
  always_comb begin
    div_d = div_q + DIV_BITS'(1);
    idx_d = idx_q;
    if (tick_s) begin
      if (idx_q == IDX_LAST) begin
        idx_d = {IDX_W{1'b0}};
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end else begin
      idx_d = idx_q;
    end
  end

  // Divider and index registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= {DIV_BITS{1'b0}};
      idx_q <= {IDX_W{1'b0}};
    end else begin
      div_q <= div_d;
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/seven_seg_mux.sv
// Multiplexed N-digit hex display driver.
// Captures a screen word into a pending buffer, promotes it to the active
// buffer only at a frame boundary (so a frame never mixes two words), then
// scans one digit per slot with leading-zero blanking, per-digit decimal
// points, PWM brightness and a dark gap at the start of every slot.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   din          hex word, digit 0 = din[3:0] (rightmost)
//   dp_in        decimal point per digit, 1 = lit
//   load         capture din/dp_in
//   lz_blank     suppress leading zeros (live)
//   brightness   PWM duty select (live)
//   seg, dp      segment and decimal-point pins
//   dig_en       one-hot digit select pins
//   frame_done   one-cycle pulse at each frame wrap
module seven_seg_mux
  import seven_seg_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int DIV_BITS   = 10,
  parameter int PWM_BITS   = 3,
  parameter int BLANK_CYC  = 4,
  parameter int SEG_ACT_LO = 1,
  parameter int DIG_ACT_LO = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   din,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  input  logic                  lz_blank,
  input  logic [PWM_BITS-1:0]   brightness,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     dig_en,
  output logic                  frame_done
);

  localparam int   IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic SEG_LO = (SEG_ACT_LO != 0);
  localparam logic DIG_LO = (DIG_ACT_LO != 0);
  localparam logic [6:0]        SEG_OFF = seg_pol(GLYPH_BLANK, SEG_LO);
  localparam logic              DP_OFF  = dp_pol(1'b0, SEG_LO);
  localparam logic [DIGITS-1:0] DIG_INV = {DIGITS{DIG_LO}};

  logic [IDX_W-1:0]    idx_s;
  logic                wrap_s;
  logic [PWM_BITS-1:0] phase_s;
  logic                slot_live_s;

  seven_seg_scan_timer #(
    .DIGITS    (DIGITS),
    .DIV_BITS  (DIV_BITS),
    .PWM_BITS  (PWM_BITS),
    .BLANK_CYC (BLANK_CYC),
    .IDX_W     (IDX_W)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .idx_o       (idx_s),
    .wrap_o      (wrap_s),
    .phase_o     (phase_s),
    .slot_live_o (slot_live_s)
  );

  logic [4*DIGITS-1:0] pend_din_q, pend_din_d, act_din_q, act_din_d;
  logic [DIGITS-1:0]   pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
  logic                pend_vld_q, pend_vld_d;

  // Double buffer: loads land in pending; the frame wrap promotes pending,
  // or a load coinciding with the wrap goes straight to active.
  always_comb begin
    pend_din_d = pend_din_q;
    pend_dp_d  = pend_dp_q;
    pend_vld_d = pend_vld_q;
    act_din_d  = act_din_q;
    act_dp_d   = act_dp_q;
    if (wrap_s) begin
      if (load) begin
        act_din_d  = din;
        act_dp_d   = dp_in;
        pend_vld_d = 1'b0;
      end else if (pend_vld_q) begin
        act_din_d  = pend_din_q;
        act_dp_d   = pend_dp_q;
        pend_vld_d = 1'b0;
      end else begin
        pend_vld_d = 1'b0;
      end
    end else if (load) begin
      pend_din_d = din;
      pend_dp_d  = dp_in;
      pend_vld_d = 1'b1;
    end else begin
      pend_vld_d = pend_vld_q;
    end
  end

  logic [DIGITS-1:0] blank_s;
  logic              zero_run_s;

  // Leading-zero mask: walk from the most significant digit down while the
  // nibbles stay zero; digit 0 is never blanked.
  always_comb begin
    blank_s    = {DIGITS{1'b0}};
    zero_run_s = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zero_run_s = zero_run_s && (act_din_q[4*k +: 4] == 4'h0);
      blank_s[k] = lz_blank && zero_run_s && (k != 0);
    end
  end

  logic              en_s;
  logic [3:0]        sel_nib_s;
  logic              sel_dp_s;
  logic              sel_blank_s;
  logic [DIGITS-1:0] dig_lit_s;
  logic [6:0]        seg_lit_s;
  logic [6:0]        seg_d;
  logic              dp_d;
  logic [DIGITS-1:0] dig_d;

  assign en_s = slot_live_s && (phase_s <= brightness);

  // Glyph/digit select for the scanned index, gated by PWM and slot blanking.
  always_comb begin
    sel_nib_s   = 4'h0;
    sel_dp_s    = 1'b0;
    sel_blank_s = 1'b0;
    dig_lit_s   = {DIGITS{1'b0}};
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_s == IDX_W'(k)) begin
        sel_nib_s    = act_din_q[4*k +: 4];
        sel_dp_s     = act_dp_q[k];
        sel_blank_s  = blank_s[k];
        dig_lit_s[k] = en_s;
      end else begin
        dig_lit_s[k] = 1'b0;
      end
    end
    seg_lit_s = sel_blank_s ? GLYPH_BLANK : GLYPH_HEX[sel_nib_s];
    seg_d     = seg_pol(seg_lit_s, SEG_LO);
    dp_d      = dp_pol(sel_dp_s, SEG_LO);
    dig_d     = dig_lit_s ^ DIG_INV;
  end

  logic [6:0]        seg_q;
  logic              dp_q;
  logic [DIGITS-1:0] dig_q;
  logic              frame_done_q;

  // Buffers and registered pin drivers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_din_q   <= {(4*DIGITS){1'b0}};
      pend_dp_q    <= {DIGITS{1'b0}};
      pend_vld_q   <= 1'b0;
      act_din_q    <= {(4*DIGITS){1'b0}};
      act_dp_q     <= {DIGITS{1'b0}};
      seg_q        <= SEG_OFF;
      dp_q         <= DP_OFF;
      dig_q        <= DIG_INV;
      frame_done_q <= 1'b0;
    end else begin
      pend_din_q   <= pend_din_d;
      pend_dp_q    <= pend_dp_d;
      pend_vld_q   <= pend_vld_d;
      act_din_q    <= act_din_d;
      act_dp_q     <= act_dp_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      dig_q        <= dig_d;
      frame_done_q <= wrap_s;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign dig_en     = dig_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_mux.sv
// Scoreboard bench: the stimulus process pushes hand-computed expected pin
// values tagged with the clock count at which they must appear; a monitor
// samples on the falling edge and pops/compares when the tag matches.
module tb_seven_seg_mux;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] din = 16'h0000;
  logic [3:0]  dp_in = 4'h0;
  logic        load = 1'b0;
  logic        lz_blank = 1'b0;
  logic [1:0]  brightness = 2'd3;

  logic [6:0] seg, seg3;
  logic       dp, dp3, fd, fd3;
  logic [3:0] dig;
  logic [2:0] dig3;

  int n = 0;
  int checks = 0;
  int fails = 0;

  typedef struct {int n; logic [6:0] seg; logic dp; logic [3:0] dig; logic fd;} exp4_t;
  typedef struct {int n; logic [6:0] seg; logic dp; logic [2:0] dig; logic fd;} exp3_t;
  exp4_t q4[$];
  exp3_t q3[$];
  event chk_ev;

  seven_seg_mux #(.DIGITS(4), .DIV_BITS(4), .PWM_BITS(2), .BLANK_CYC(1),
                  .SEG_ACT_LO(1), .DIG_ACT_LO(1)) u_dut (
    .clk(clk), .rst(rst), .din(din), .dp_in(dp_in), .load(load),
    .lz_blank(lz_blank), .brightness(brightness),
    .seg(seg), .dp(dp), .dig_en(dig), .frame_done(fd));

  seven_seg_mux #(.DIGITS(3), .DIV_BITS(4), .PWM_BITS(2), .BLANK_CYC(1),
                  .SEG_ACT_LO(1), .DIG_ACT_LO(1)) u_dut3 (
    .clk(clk), .rst(rst), .din(din[11:0]), .dp_in(dp_in[2:0]), .load(load),
    .lz_blank(lz_blank), .brightness(brightness),
    .seg(seg3), .dp(dp3), .dig_en(dig3), .frame_done(fd3));

  always #5 clk = ~clk;

  // Clock edges since reset release.
  always @(posedge clk or posedge rst) begin
    if (rst) n <= 0;
    else     n <= n + 1;
  end

  function automatic void p4(input int t, input logic [6:0] s, input logic d,
                             input logic [3:0] g, input logic f);
    q4.push_back('{t, s, d, g, f});
  endfunction

  function automatic void p3(input int t, input logic [6:0] s, input logic d,
                             input logic [2:0] g, input logic f);
    q3.push_back('{t, s, d, g, f});
  endfunction

  task automatic wait_n(input int k);
    while (n < k) @(negedge clk);
  endtask

  // Drive load so the DUT samples it at edge number m.
  task automatic load_at(input int m, input logic [15:0] d, input logic [3:0] p);
    wait_n(m - 1);
    din = d;
    dp_in = p;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Monitor.
  initial begin
    exp4_t e4;
    exp3_t e3;
    forever begin
      @(negedge clk or chk_ev);
      while (q4.size() > 0 && q4[0].n < n) begin
        e4 = q4.pop_front();
        checks++; fails++;
        $display("FAIL missed4 tag=%0d now=%0d", e4.n, n);
      end
      if (q4.size() > 0 && q4[0].n == n) begin
        e4 = q4.pop_front();
        checks++;
        if (seg !== e4.seg || dp !== e4.dp || dig !== e4.dig || fd !== e4.fd) begin
          fails++;
          $display("FAIL scan4 n=%0d got seg=%h dp=%b dig=%b fd=%b want seg=%h dp=%b dig=%b fd=%b",
                   n, seg, dp, dig, fd, e4.seg, e4.dp, e4.dig, e4.fd);
        end
      end
      while (q3.size() > 0 && q3[0].n < n) begin
        e3 = q3.pop_front();
        checks++; fails++;
        $display("FAIL missed3 tag=%0d now=%0d", e3.n, n);
      end
      if (q3.size() > 0 && q3[0].n == n) begin
        e3 = q3.pop_front();
        checks++;
        if (seg3 !== e3.seg || dp3 !== e3.dp || dig3 !== e3.dig || fd3 !== e3.fd) begin
          fails++;
          $display("FAIL scan3 n=%0d got seg=%h dp=%b dig=%b fd=%b want seg=%h dp=%b dig=%b fd=%b",
                   n, seg3, dp3, dig3, fd3, e3.seg, e3.dp, e3.dig, e3.fd);
        end
      end
    end
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Stimulus.
  initial begin
    exp4_t e4;
    exp3_t e3;
    #1 rst = 1'b1;
    #1;
    p4(0, 7'h7F, 1'b1, 4'hF, 1'b0);
    p3(0, 7'h7F, 1'b1, 3'h7, 1'b0);
    -> chk_ev;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // 4-digit expectations (blank "0" before first load, then 12AF etc.)
    p4(64,  7'h40, 1'b1, 4'h7, 1'b1);
    p4(65,  7'h0E, 1'b1, 4'hF, 1'b0);
    p4(66,  7'h0E, 1'b1, 4'hE, 1'b0);
    p4(82,  7'h08, 1'b1, 4'hD, 1'b0);
    p4(98,  7'h24, 1'b0, 4'hB, 1'b0);
    p4(114, 7'h79, 1'b1, 4'h7, 1'b0);
    p4(127, 7'h79, 1'b1, 4'h7, 1'b0);
    p4(128, 7'h79, 1'b1, 4'h7, 1'b1);
    p4(146, 7'h08, 1'b1, 4'hD, 1'b0);
    p4(192, 7'h79, 1'b1, 4'h7, 1'b1);
    p4(194, 7'h24, 1'b1, 4'hE, 1'b0);
    p4(242, 7'h24, 1'b1, 4'h7, 1'b0);
    p4(258, 7'h02, 1'b0, 4'hE, 1'b0);
    p4(306, 7'h30, 1'b1, 4'h7, 1'b0);
    p4(322, 7'h40, 1'b1, 4'hE, 1'b0);
    p4(338, 7'h30, 1'b1, 4'hD, 1'b0);
    p4(354, 7'h7F, 1'b1, 4'hB, 1'b0);
    p4(370, 7'h7F, 1'b1, 4'h7, 1'b0);
    p4(386, 7'h40, 1'b1, 4'hE, 1'b0);
    p4(402, 7'h7F, 1'b1, 4'hD, 1'b0);
    p4(434, 7'h7F, 1'b0, 4'h7, 1'b0);
    p4(465, 7'h7F, 1'b1, 4'hF, 1'b0);
    p4(466, 7'h7F, 1'b1, 4'hD, 1'b0);
    p4(468, 7'h7F, 1'b1, 4'hD, 1'b0);
    p4(469, 7'h7F, 1'b1, 4'hF, 1'b0);
    p4(480, 7'h7F, 1'b1, 4'hF, 1'b0);
    // 3-digit build: wrap 2 -> 0 at 48 clocks
    p3(34, 7'h40, 1'b1, 3'b011, 1'b0);
    p3(47, 7'h40, 1'b1, 3'b011, 1'b0);
    p3(48, 7'h40, 1'b1, 3'b011, 1'b1);
    p3(50, 7'h0E, 1'b1, 3'b110, 1'b0);

    load_at(30,  16'h12AF, 4'b0100);
    load_at(140, 16'h1111, 4'b0000);
    load_at(150, 16'h2222, 4'b0000);
    load_at(256, 16'h3456, 4'b0001);
    lz_blank = 1'b1;
    load_at(270, 16'h0030, 4'b0000);
    load_at(340, 16'h0000, 4'b1000);
    wait_n(440);
    brightness = 2'd0;
    load_at(495, 16'h8888, 4'b0000);

    // Mid-scan reset: outputs must go idle before the next clock edge.
    wait_n(500);
    rst = 1'b1;
    #1;
    p4(0, 7'h7F, 1'b1, 4'hF, 1'b0);
    p3(0, 7'h7F, 1'b1, 3'h7, 1'b0);
    -> chk_ev;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    // Pending 8888 must be gone; lz_blank=1, brightness=0 still live.
    p4(2,  7'h40, 1'b1, 4'hE, 1'b0);
    p4(18, 7'h7F, 1'b1, 4'hD, 1'b0);
    p4(63, 7'h7F, 1'b1, 4'hF, 1'b0);
    p4(64, 7'h7F, 1'b1, 4'hF, 1'b1);
    p4(66, 7'h40, 1'b1, 4'hE, 1'b0);
    wait_n(70);
    @(negedge clk);
    #1;

    while (q4.size() > 0) begin
      e4 = q4.pop_front();
      checks++; fails++;
      $display("FAIL unchecked4 tag=%0d", e4.n);
    end
    while (q3.size() > 0) begin
      e3 = q3.pop_front();
      checks++; fails++;
      $display("FAIL unchecked3 tag=%0d", e3.n);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
